// File: rtl/calc_pkg.sv
// Shared op encodings and FSM state type for the sequential calculator.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // mul and div run on the iterative core; add and sub finish in one cycle
    function automatic logic is_iterative(input op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_muldiv_core.sv
// Iterative N-cycle shift-add multiplier and restoring divider.
// Outputs carry the value of the step in progress, so they are final when done=1.
module calc_muldiv_core #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           op_div,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder
);

    localparam int CW = $clog2(N);

    logic          busy;
    logic          div_q;
    logic [CW-1:0] cnt;
    logic [2*N-1:0] acc;
    logic [N-1:0]  opnd;
    logic [N-1:0]  rem;
    logic [N-1:0]  quo;

    logic [N:0]     add_sum;
    logic [2*N-1:0] acc_nx;
    logic [N:0]     r_shift;
    logic [N-1:0]   trial;
    logic [N-1:0]   rem_nx;
    logic [N-1:0]   quo_nx;

    always_comb begin
        add_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
        acc_nx  = {add_sum, acc[N-1:1]};
        r_shift = {rem, quo[N-1]};
        // when the trial subtraction succeeds the difference is below the divisor, so N bits suffice
        trial   = r_shift[N-1:0] - opnd;
        rem_nx  = r_shift[N-1:0];
        quo_nx  = {quo[N-2:0], 1'b0};
        if (r_shift >= {1'b0, opnd}) begin
            rem_nx = trial;
            quo_nx = {quo[N-2:0], 1'b1};
        end
    end

    assign done      = busy && (cnt == CW'(N - 1));
    assign product   = acc_nx;
    assign quotient  = quo_nx;
    assign remainder = rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            rem   <= '0;
            quo   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= op_div;
            cnt   <= '0;
            if (op_div) begin
                opnd <= b;
                rem  <= '0;
                quo  <= a;
            end else begin
                opnd <= a;
                acc  <= {{N{1'b0}}, b};
            end
        end else if (busy) begin
            if (div_q) begin
                rem <= rem_nx;
                quo <= quo_nx;
            end else begin
                acc <= acc_nx;
            end
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_seq_unit.sv
// Sequential calculator: one request at a time, add/sub in 1 cycle, mul/div in N cycles.
// Handshake: a transfer happens on an edge where valid and ready are both 1; valid never depends on ready.
module calc_seq_unit
    import calc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [1:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Result,
    output logic           C_out,
    output logic [1:0]     state_dbg
);

    state_e state, state_nx;
    op_e    op_in;
    op_e    op_q;
    logic [N-1:0] a_q, b_q;

    logic           accept;
    logic           core_start;
    logic           core_done;
    logic [2*N-1:0] core_product;
    logic [N-1:0]   core_quotient;
    logic [N-1:0]   core_remainder;

    logic           load_result;
    logic [2*N-1:0] result_nx;
    logic           c_nx;
    logic [N:0]     add_sum;
    logic [N:0]     sub_diff;

    assign op_in      = op_e'(op);
    assign accept     = (state == IDLE) && in_valid;
    assign core_start = accept && is_iterative(op_in);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign state_dbg  = state;

    calc_muldiv_core #(.N(N)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .op_div    (op_in == OP_DIV),
        .a         (A),
        .b         (B),
        .done      (core_done),
        .product   (core_product),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

    always_comb begin
        add_sum  = {1'b0, a_q} + {1'b0, b_q};
        sub_diff = {1'b0, a_q} - {1'b0, b_q};
    end

    always_comb begin
        state_nx    = state;
        load_result = 1'b0;
        result_nx   = '0;
        c_nx        = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                case (op_q)
                    OP_ADD: begin
                        load_result = 1'b1;
                        result_nx   = {{N{1'b0}}, add_sum[N-1:0]};
                        c_nx        = add_sum[N];
                    end
                    OP_SUB: begin
                        load_result = 1'b1;
                        result_nx   = {{N{1'b0}}, sub_diff[N-1:0]};
                        c_nx        = sub_diff[N];
                    end
                    OP_MUL: begin
                        load_result = core_done;
                        result_nx   = core_product;
                    end
                    default: begin
                        // a zero divisor naturally yields all-ones quotient and remainder A
                        load_result = core_done;
                        result_nx   = {core_remainder, core_quotient};
                        c_nx        = (b_q == '0);
                    end
                endcase
                if (load_result) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            Result <= '0;
            C_out  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= op_in;
                a_q  <= A;
                b_q  <= B;
            end
            if (load_result) begin
                Result <= result_nx;
                C_out  <= c_nx;
            end
        end
    end

endmodule
